// File: rtl/alu_pkg.sv
// Shared types for the sequential accumulator ALU: encoded opcodes and controller states.
package alu_pkg;

  typedef enum logic [2:0] {
    OP_LOAD = 3'd0,
    OP_ADD  = 3'd1,
    OP_SUB  = 3'd2,
    OP_XOR  = 3'd3,
    OP_AND  = 3'd4,
    OP_OR   = 3'd5,
    OP_SHR  = 3'd6,
    OP_MUL  = 3'd7
  } alu_op_t;

  typedef enum logic {
    IDLE = 1'b0,
    MUL  = 1'b1
  } alu_state_t;

endpackage

// File: rtl/alu_seq_mul.sv
// Shift-add unsigned multiplier: one multiplier bit per clock, full 2*WORD_W product.
module alu_mul_seq #(
  parameter int WORD_W = 8
) (
  input  logic                  clock,
  input  logic                  n_reset,
  input  logic                  go,
  input  logic [WORD_W-1:0]     a,
  input  logic [WORD_W-1:0]     b,
  output logic                  busy,
  output logic [2*WORD_W-1:0]   product,
  output logic                  last
);

  localparam int CNT_W = $clog2(WORD_W + 1);

  logic [2*WORD_W-1:0] r_mcand;
  logic [2*WORD_W-1:0] r_part;
  logic [WORD_W-1:0]   r_mplier;
  logic [CNT_W-1:0]    r_count;
  logic                r_busy;
  logic [2*WORD_W-1:0] w_part_nxt;

  // product includes the addition made on the final edge, so the result is ready on that edge
  assign w_part_nxt = r_mplier[0] ? (r_part + r_mcand) : r_part;
  assign product    = w_part_nxt;
  assign last       = r_busy && (r_count == CNT_W'(WORD_W - 1));
  assign busy       = r_busy;

  always_ff @(posedge clock or negedge n_reset) begin
    if (!n_reset) begin
      r_mcand  <= '0;
      r_part   <= '0;
      r_mplier <= '0;
      r_count  <= '0;
      r_busy   <= 1'b0;
    end else if (go && !r_busy) begin
      r_mcand  <= {{WORD_W{1'b0}}, a};
      r_mplier <= b;
      r_part   <= '0;
      r_count  <= '0;
      r_busy   <= 1'b1;
    end else if (r_busy) begin
      r_part   <= w_part_nxt;
      r_mplier <= r_mplier >> 1;
      r_mcand  <= r_mcand << 1;
      r_count  <= r_count + CNT_W'(1);
      if (last) r_busy <= 1'b0;
    end
  end

endmodule

// File: rtl/alu_seq.sv
// Accumulator ALU on the shared sysbus: single-cycle ops plus a multicycle multiply.
// IDLE | accepts start, single-cycle ops complete here ; MUL | multiplier running, start ignored
module alu_seq
  import alu_pkg::*;
#(
  parameter int WORD_W = 8,
  parameter int OP_W   = 3
) (
  input  logic              clock,
  input  logic              n_reset,
  input  logic              ACC_bus,
  input  logic              start,
  input  logic [OP_W-1:0]   op,
  inout  wire  [WORD_W-1:0] sysbus,
  output logic              busy,
  output logic              done,
  output logic              z_flag,
  output logic              n_flag,
  output logic              c_flag,
  output logic              v_flag
);

  alu_state_t            r_state, w_state_nxt;
  logic [WORD_W-1:0]     r_acc, w_acc_nxt;
  logic                  r_c, r_v, r_done;
  logic                  w_c_nxt, w_v_nxt, w_upd, w_go;
  alu_op_t               w_op;
  logic [WORD_W-1:0]     w_bus;
  logic [WORD_W:0]       w_sum, w_diff;
  logic                  w_mul_busy, w_mul_last;
  logic [2*WORD_W-1:0]   w_product;

  assign sysbus = ACC_bus ? r_acc : 'z;
  assign w_bus  = sysbus;
  assign w_op   = alu_op_t'(op[2:0]);
  assign w_sum  = {1'b0, r_acc} + {1'b0, w_bus};
  assign w_diff = {1'b0, r_acc} - {1'b0, w_bus};

  alu_mul_seq #(.WORD_W(WORD_W)) u_mul (
    .clock   (clock),
    .n_reset (n_reset),
    .go      (w_go),
    .a       (r_acc),
    .b       (w_bus),
    .busy    (w_mul_busy),
    .product (w_product),
    .last    (w_mul_last)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_acc_nxt   = r_acc;
    w_c_nxt     = r_c;
    w_v_nxt     = r_v;
    w_upd       = 1'b0;
    w_go        = 1'b0;
    case (r_state)
      IDLE: begin
        if (start) begin
          if (w_op == OP_MUL) begin
            w_go        = 1'b1;
            w_state_nxt = MUL;
          end else begin
            w_upd = 1'b1;
            case (w_op)
              OP_LOAD: w_acc_nxt = w_bus;
              OP_ADD: begin
                w_acc_nxt = w_sum[WORD_W-1:0];
                w_c_nxt   = w_sum[WORD_W];
                w_v_nxt   = (r_acc[WORD_W-1] == w_bus[WORD_W-1]) &&
                            (w_sum[WORD_W-1] != r_acc[WORD_W-1]);
              end
              OP_SUB: begin
                // borrow appears as the extended MSB of the difference
                w_acc_nxt = w_diff[WORD_W-1:0];
                w_c_nxt   = w_diff[WORD_W];
                w_v_nxt   = (r_acc[WORD_W-1] != w_bus[WORD_W-1]) &&
                            (w_diff[WORD_W-1] != r_acc[WORD_W-1]);
              end
              OP_XOR: begin w_acc_nxt = r_acc ^ w_bus; w_c_nxt = 1'b0; w_v_nxt = 1'b0; end
              OP_AND: begin w_acc_nxt = r_acc & w_bus; w_c_nxt = 1'b0; w_v_nxt = 1'b0; end
              OP_OR:  begin w_acc_nxt = r_acc | w_bus; w_c_nxt = 1'b0; w_v_nxt = 1'b0; end
              OP_SHR: begin
                w_acc_nxt = {1'b0, r_acc[WORD_W-1:1]};
                w_c_nxt   = r_acc[0];
                w_v_nxt   = 1'b0;
              end
              default: w_upd = 1'b0;
            endcase
          end
        end
      end
      MUL: begin
        if (w_mul_last) begin
          w_upd       = 1'b1;
          w_acc_nxt   = w_product[WORD_W-1:0];
          w_c_nxt     = |w_product[2*WORD_W-1:WORD_W];
          w_v_nxt     = |w_product[2*WORD_W-1:WORD_W];
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge n_reset) begin
    if (!n_reset) begin
      r_state <= IDLE;
      r_acc   <= '0;
      r_c     <= 1'b0;
      r_v     <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_done  <= w_upd;
      if (w_upd) begin
        r_acc <= w_acc_nxt;
        r_c   <= w_c_nxt;
        r_v   <= w_v_nxt;
      end
    end
  end

  assign busy   = w_mul_busy;
  assign done   = r_done;
  assign z_flag = (r_acc == '0);
  assign n_flag = r_acc[WORD_W-1];
  assign c_flag = r_c;
  assign v_flag = r_v;

endmodule

// File: tb/tb_alu_seq.sv
// Directed testbench for alu_seq (WORD_W=8): hand-computed results, flags and handshake timing.
module tb_alu_seq;

  logic       clock = 1'b0;
  logic       n_reset = 1'b0;
  logic       ACC_bus = 1'b0;
  logic       start = 1'b0;
  logic [2:0] op = 3'd0;
  logic [7:0] drv = 8'h00;
  logic       drv_en = 1'b0;
  wire  [7:0] sysbus;
  logic       busy, done, z_flag, n_flag, c_flag, v_flag;

  int n_vec = 0;
  int n_err = 0;

  assign sysbus = drv_en ? drv : 8'bz;

  always #5 clock = ~clock;

  alu_seq #(.WORD_W(8), .OP_W(3)) dut (
    .clock   (clock),
    .n_reset (n_reset),
    .ACC_bus (ACC_bus),
    .start   (start),
    .op      (op),
    .sysbus  (sysbus),
    .busy    (busy),
    .done    (done),
    .z_flag  (z_flag),
    .n_flag  (n_flag),
    .c_flag  (c_flag),
    .v_flag  (v_flag)
  );

  task automatic issue(input logic [2:0] o, input logic [7:0] d);
    @(negedge clock);
    ACC_bus = 1'b0; start = 1'b1; op = o; drv = d; drv_en = 1'b1;
    @(posedge clock); #1;
    start = 1'b0; drv_en = 1'b0;
  endtask

  task automatic read_acc(output logic [7:0] val);
    ACC_bus = 1'b1; #1;
    val = sysbus;
    ACC_bus = 1'b0; #1;
  endtask

  task automatic test_reset;
    logic [7:0] a;
    n_reset = 1'b0; ACC_bus = 1'b1;
    #12;
    n_vec++; if (sysbus !== 8'h00) begin n_err++; $display("FAIL reset_acc got=%h exp=00", sysbus); end
    n_vec++; if ({z_flag, n_flag, c_flag, v_flag} !== 4'b1000) begin n_err++; $display("FAIL reset_flags got=%b exp=1000", {z_flag, n_flag, c_flag, v_flag}); end
    n_vec++; if ({busy, done} !== 2'b00) begin n_err++; $display("FAIL reset_busy_done got=%b exp=00", {busy, done}); end
    @(negedge clock); n_reset = 1'b1; ACC_bus = 1'b0;
    drv = 8'h5A; drv_en = 1'b1; #1;
    a = sysbus;
    n_vec++; if (a !== 8'h5A) begin n_err++; $display("FAIL bus_released got=%h exp=5a", a); end
    drv_en = 1'b0;
  endtask

  task automatic test_add_sub;
    logic [7:0] a;
    issue(3'd0, 8'h7F);
    n_vec++; if (done !== 1'b1) begin n_err++; $display("FAIL load_done got=%b exp=1", done); end
    read_acc(a);
    n_vec++; if (a !== 8'h7F) begin n_err++; $display("FAIL load_acc got=%h exp=7f", a); end
    issue(3'd1, 8'h01);
    n_vec++; if (done !== 1'b1) begin n_err++; $display("FAIL add_done got=%b exp=1", done); end
    read_acc(a);
    n_vec++; if (a !== 8'h80) begin n_err++; $display("FAIL add_acc got=%h exp=80", a); end
    n_vec++; if ({z_flag, n_flag, c_flag, v_flag} !== 4'b0101) begin n_err++; $display("FAIL add_flags znc v got=%b exp=0101", {z_flag, n_flag, c_flag, v_flag}); end
    @(posedge clock); #1;
    n_vec++; if (done !== 1'b0) begin n_err++; $display("FAIL add_done_width got=%b exp=0", done); end
    issue(3'd2, 8'h81);
    read_acc(a);
    n_vec++; if (a !== 8'hFF) begin n_err++; $display("FAIL sub_acc got=%h exp=ff", a); end
    n_vec++; if ({z_flag, n_flag, c_flag, v_flag} !== 4'b0110) begin n_err++; $display("FAIL sub_flags got=%b exp=0110", {z_flag, n_flag, c_flag, v_flag}); end
  endtask

  task automatic test_mul;
    logic [7:0] a;
    int cyc = 0;
    int dn = 0;
    issue(3'd0, 8'h0C);
    issue(3'd7, 8'h0B);
    n_vec++; if ({busy, done} !== 2'b10) begin n_err++; $display("FAIL mul_start busy/done got=%b exp=10", {busy, done}); end
    while (busy === 1'b1 && cyc < 20) begin
      @(posedge clock); #1; cyc++;
      if (done === 1'b1) dn++;
    end
    read_acc(a);
    n_vec++; if (a !== 8'h84) begin n_err++; $display("FAIL mul_acc got=%h exp=84", a); end
    n_vec++; if ({c_flag, v_flag} !== 2'b00) begin n_err++; $display("FAIL mul_cv got=%b exp=00", {c_flag, v_flag}); end
    @(posedge clock); #1;
    if (done === 1'b1) dn++;
    n_vec++; if (cyc !== 8) begin n_err++; $display("FAIL mul_busy_cycles got=%0d exp=8", cyc); end
    n_vec++; if (dn !== 1) begin n_err++; $display("FAIL mul_done_pulses got=%0d exp=1", dn); end
  endtask

  task automatic test_mul_overflow_ignore;
    logic [7:0] a;
    int cyc = 0;
    issue(3'd0, 8'h20);
    issue(3'd7, 8'h10);
    issue(3'd1, 8'h55);
    cyc = 1;
    n_vec++; if ({busy, done} !== 2'b10) begin n_err++; $display("FAIL ignore_start busy/done got=%b exp=10", {busy, done}); end
    while (busy === 1'b1 && cyc < 20) begin
      @(posedge clock); #1; cyc++;
    end
    n_vec++; if (cyc !== 8) begin n_err++; $display("FAIL ovf_busy_cycles got=%0d exp=8", cyc); end
    n_vec++; if (done !== 1'b1) begin n_err++; $display("FAIL ovf_done got=%b exp=1", done); end
    read_acc(a);
    n_vec++; if (a !== 8'h00) begin n_err++; $display("FAIL ovf_acc got=%h exp=00", a); end
    n_vec++; if ({z_flag, n_flag, c_flag, v_flag} !== 4'b1011) begin n_err++; $display("FAIL ovf_flags got=%b exp=1011", {z_flag, n_flag, c_flag, v_flag}); end
  endtask

  task automatic test_shr;
    logic [7:0] a;
    issue(3'd0, 8'h03);
    n_vec++; if ({c_flag, v_flag} !== 2'b11) begin n_err++; $display("FAIL load_keeps_cv got=%b exp=11", {c_flag, v_flag}); end
    issue(3'd6, 8'hAA);
    read_acc(a);
    n_vec++; if (a !== 8'h01) begin n_err++; $display("FAIL shr1_acc got=%h exp=01", a); end
    n_vec++; if ({c_flag, v_flag} !== 2'b10) begin n_err++; $display("FAIL shr1_cv got=%b exp=10", {c_flag, v_flag}); end
    issue(3'd6, 8'hFF);
    read_acc(a);
    n_vec++; if (a !== 8'h00) begin n_err++; $display("FAIL shr2_acc got=%h exp=00", a); end
    n_vec++; if ({z_flag, c_flag} !== 2'b11) begin n_err++; $display("FAIL shr2_zc got=%b exp=11", {z_flag, c_flag}); end
    issue(3'd4, 8'hFF);
    n_vec++; if ({z_flag, c_flag, v_flag} !== 3'b100) begin n_err++; $display("FAIL and_flags got=%b exp=100", {z_flag, c_flag, v_flag}); end
    issue(3'd5, 8'h3C);
    issue(3'd3, 8'h0F);
    read_acc(a);
    n_vec++; if (a !== 8'h33) begin n_err++; $display("FAIL or_xor_acc got=%h exp=33", a); end
  endtask

  task automatic test_reset_abort;
    logic [7:0] a;
    int cyc = 0;
    int dn = 0;
    issue(3'd0, 8'h05);
    issue(3'd7, 8'h07);
    repeat (3) begin @(posedge clock); #1; if (done === 1'b1) dn++; end
    @(negedge clock); n_reset = 1'b0; #1;
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL abort_busy got=%b exp=0", busy); end
    read_acc(a);
    n_vec++; if (a !== 8'h00) begin n_err++; $display("FAIL abort_acc got=%h exp=00", a); end
    repeat (2) begin @(posedge clock); #1; if (done === 1'b1) dn++; end
    @(negedge clock); n_reset = 1'b1;
    repeat (10) begin @(posedge clock); #1; if (done === 1'b1 || busy === 1'b1) dn++; end
    n_vec++; if (dn !== 0) begin n_err++; $display("FAIL abort_no_done got=%0d exp=0", dn); end
    issue(3'd7, 8'h07);
    while (busy === 1'b1 && cyc < 20) begin
      @(posedge clock); #1; cyc++;
    end
    n_vec++; if (cyc !== 8) begin n_err++; $display("FAIL remul_cycles got=%0d exp=8", cyc); end
    n_vec++; if (done !== 1'b1) begin n_err++; $display("FAIL remul_done got=%b exp=1", done); end
    read_acc(a);
    n_vec++; if (a !== 8'h00 || z_flag !== 1'b1 || {c_flag, v_flag} !== 2'b00) begin n_err++; $display("FAIL remul_result acc=%h z=%b cv=%b exp acc=00 z=1 cv=00", a, z_flag, {c_flag, v_flag}); end
  endtask

  initial begin
    test_reset();
    test_add_sub();
    test_mul();
    test_mul_overflow_ignore();
    test_shr();
    test_reset_abort();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
